// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: one outstanding imem read, prefetch FIFO of {pc, word},
// and a redirect that flushes the FIFO and retires stale in-flight data.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        ins_valid,
    input  logic        ins_ready,
    output logic [31:0] ins_data,
    output logic [31:0] ins_pc
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRAIN} state_t;

    state_t        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic          req_q, req_d;
    logic [31:0]   addr_q, addr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   fifo_data_q [DEPTH];
    logic [31:0]   fifo_data_d [DEPTH];
    logic [31:0]   fifo_pc_q   [DEPTH];
    logic [31:0]   fifo_pc_d   [DEPTH];

    logic          ack, pop, push, issue;
    logic [31:0]   issue_pc, redir_pc;
    logic [CW-1:0] count_nxt;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_d      = req_q;
        addr_d     = addr_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_data_d = fifo_data_q;
        fifo_pc_d   = fifo_pc_q;
        redir_pc   = {redirect_pc[31:2], 2'b00};
        ack        = imem_ack & req_q;
        pop        = (count_q != '0) & ins_ready & ~redirect_valid;
        push       = 1'b0;
        issue      = 1'b0;
        issue_pc   = fetch_pc_q;

        case (state_q)
            S_IDLE: begin
                if (redirect_valid) begin
                    issue    = 1'b1;
                    issue_pc = redir_pc;
                end else if (count_q < DEPTH_C) begin
                    issue = 1'b1;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    if (ack) begin
                        issue    = 1'b1;
                        issue_pc = redir_pc;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end else if (ack) begin
                    push       = 1'b1;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                end
            end
            S_DRAIN: begin
                if (ack) begin
                    issue    = 1'b1;
                    issue_pc = redirect_valid ? redir_pc : fetch_pc_q;
                end
            end
            default: state_d = S_IDLE;
        endcase

        count_nxt = count_q + CW'(push) - CW'(pop);

        // Re-issue back to back only while the FIFO still has room after this edge.
        if (push) begin
            fifo_data_d[wr_ptr_q] = imem_rdata;
            fifo_pc_d[wr_ptr_q]   = fetch_pc_q;
            wr_ptr_d              = wr_ptr_q + PW'(1);
            if (count_nxt < DEPTH_C) begin
                issue    = 1'b1;
                issue_pc = fetch_pc_d;
            end else begin
                req_d   = 1'b0;
                state_d = S_IDLE;
            end
        end
        if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
        count_d = count_nxt;

        if (redirect_valid) begin
            fetch_pc_d = redir_pc;
            count_d    = '0;
            rd_ptr_d   = wr_ptr_q;
        end

        if (issue) begin
            req_d   = 1'b1;
            addr_d  = issue_pc;
            state_d = S_WAIT;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            req_q      <= 1'b0;
            addr_q     <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_data_q[i] <= '0;
                fifo_pc_q[i]   <= '0;
            end
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            req_q       <= req_d;
            addr_q      <= addr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            fifo_data_q <= fifo_data_d;
            fifo_pc_q   <= fifo_pc_d;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign ins_valid = (count_q != '0);
    assign ins_data  = fifo_data_q[rd_ptr_q];
    assign ins_pc    = fifo_pc_q[rd_ptr_q];
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus random traffic against a
// transaction-level model (queue of fetched words, outstanding/stale flags).
module tb_instr_fetch_unit;
    localparam int DEPTH = 2;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        imem_req, imem_ack, redirect_valid, ins_valid, ins_ready;
    logic [31:0] imem_addr, imem_rdata, redirect_pc, ins_data, ins_pc;
    logic        req5, valid5;
    logic [31:0] addr5, rdata5, data5, pc5;
    bit          mixmode;

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] mem(input logic [31:0] a, input bit mix);
        return mix ? ((a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F) : (a | 32'hA000_0000);
    endfunction

    assign imem_rdata = mem(imem_addr, mixmode);
    assign rdata5     = mem(addr5, 1'b0);

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RESET(RESET), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .ins_valid(ins_valid), .ins_ready(ins_ready),
        .ins_data(ins_data), .ins_pc(ins_pc));

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) dut5 (
        .CLK(CLK), .RESET(RESET), .imem_req(req5), .imem_addr(addr5),
        .imem_ack(1'b1), .imem_rdata(rdata5), .redirect_valid(1'b0),
        .redirect_pc(32'h0), .ins_valid(valid5), .ins_ready(1'b1),
        .ins_data(data5), .ins_pc(pc5));

    always #5 CLK = ~CLK;

    // Reference model state
    logic [63:0] mq[$];
    logic [31:0] m_fpc, m_addr;
    bit          m_out, m_stale;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        mq.delete();
        m_fpc = 32'h0; m_addr = 32'h0; m_out = 0; m_stale = 0;
    endtask

    task automatic m_issue(input logic [31:0] a);
        m_out = 1; m_addr = a; m_stale = 0;
    endtask

    task automatic compare();
        chk("imem_req", 32'(imem_req), 32'(m_out));
        if (m_out) chk("imem_addr", imem_addr, m_addr);
        chk("ins_valid", 32'(ins_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("ins_pc", ins_pc, mq[0][63:32]);
            chk("ins_data", ins_data, mq[0][31:0]);
        end
    endtask

    // One clock: drive at negedge, advance model, check after posedge, return at negedge.
    task automatic step(input bit ack, input bit rv, input logic [31:0] rpc, input bit rdy);
        bit ackv, can_issue;
        imem_ack = ack; redirect_valid = rv; redirect_pc = rpc; ins_ready = rdy;
        #1;
        ackv = ack && m_out;
        if (rv) begin
            mq.delete();
            m_fpc = rpc & ~32'h3;
            if (!m_out || ackv) m_issue(m_fpc);
            else m_stale = 1;
        end else begin
            can_issue = mq.size() < DEPTH;
            if (rdy && mq.size() != 0) void'(mq.pop_front());
            if (!m_out) begin
                if (can_issue) m_issue(m_fpc);
            end else if (ackv && m_stale) begin
                m_issue(m_fpc);
            end else if (ackv) begin
                mq.push_back({m_fpc, mem(m_addr, mixmode)});
                m_fpc = m_fpc + 32'd4;
                if (mq.size() < DEPTH) m_issue(m_fpc);
                else m_out = 0;
            end
        end
        @(posedge CLK);
        #1;
        compare();
        @(negedge CLK);
    endtask

    task automatic chk_reset_vals();
        chk("rst_req", 32'(imem_req), 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", 32'(ins_valid), 32'h0);
        chk("rst_data", ins_data, 32'h0);
        chk("rst_pc", ins_pc, 32'h0);
        chk("rst5_addr", addr5, 32'hFFFF_FFF8);
        chk("rst5_valid", 32'(valid5), 32'h0);
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        imem_ack = 0; redirect_valid = 0; redirect_pc = 0; ins_ready = 0;
        m_reset();
        @(negedge CLK);
        @(negedge CLK);
        chk_reset_vals();
        RESET = 1'b0;
    endtask

    initial begin
        imem_ack = 0; redirect_valid = 0; redirect_pc = 0; ins_ready = 0;
        mixmode = 0;

        // Streaming with ack and ready tied high; wrap-around instance checked alongside.
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            step(1, 0, 32'h0, 1);
            if (i == 1) chk("wrap_addr", addr5, 32'hFFFF_FFF8);
            if (i == 2) chk("wrap_pc0", pc5, 32'hFFFF_FFF8);
            if (i == 3) chk("wrap_pc1", pc5, 32'hFFFF_FFFC);
            if (i == 4) begin
                chk("wrap_pc2", pc5, 32'h0000_0000);
                chk("wrap_data2", data5, 32'hA000_0000);
            end
            if (i >= 2) chk("stream_pc", ins_pc, 32'((i - 2) * 4));
        end

        // Redirect coinciding with ack and pop.
        step(1, 1, 32'h103, 1);
        chk("redir_addr", imem_addr, 32'h100);
        chk("redir_valid", 32'(ins_valid), 32'h0);

        // Backpressure fills the FIFO and parks the request.
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 0, 32'h0, 0);
        chk("full_req", 32'(imem_req), 32'h0);
        chk("full_pc0", ins_pc, 32'h0);
        step(0, 0, 32'h0, 1);
        chk("drain_pc1", ins_pc, 32'h4);

        // Redirect during a slow read: stale data dropped.
        do_reset();
        step(0, 0, 32'h0, 1);
        step(0, 1, 32'h40, 1);
        step(0, 0, 32'h0, 1);
        step(1, 0, 32'h0, 1);
        chk("drain_addr", imem_addr, 32'h40);
        chk("drain_novalid", 32'(ins_valid), 32'h0);
        step(1, 0, 32'h0, 1);
        chk("drain_pc", ins_pc, 32'h40);

        // Asynchronous reset with a read outstanding and data buffered.
        do_reset();
        step(1, 0, 32'h0, 0);
        step(1, 0, 32'h0, 0);
        chk("pre_rst_req", 32'(imem_req), 32'h1);
        #2;
        RESET = 1'b1;
        #1;
        chk_reset_vals();
        m_reset();
        @(negedge CLK);
        RESET = 1'b0;

        // Random traffic against the model.
        mixmode = 1;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic [31:0] rpc;
            rpc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : $urandom();
            step($urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0, rpc,
                 $urandom_range(0, 3) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
